// File: rtl/forward_scoreboard_pkg.sv
// Shared types for the forwarding scoreboard: slot entry layout and select-width helper.
package forward_scoreboard_pkg;

  localparam int REGW_DEF = 5;
  localparam int LATW_DEF = 2;

  typedef logic [REGW_DEF-1:0] regbits_t;
  typedef logic [LATW_DEF-1:0] latbits_t;

  typedef struct packed {
    logic     vld;
    regbits_t rd;
    latbits_t rem;
  } slot_t;

  // One extra code point beyond DEPTH is needed for "read the register file".
  function automatic int fwd_sel_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/forward_scoreboard_fwd_match.sv
// Per-source youngest-producer search: picks a forward slot or flags a stall.
module fwd_match
  import forward_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SELW  = fwd_sel_width(DEPTH)
) (
  input  slot_t [DEPTH-1:0] slots,
  input  regbits_t          src,
  output logic [SELW-1:0]   sel,
  output logic              stall
);

  logic found;

  // Slot 0 is youngest, so the first hit while scanning upward wins.
  always_comb begin
    sel   = '0;
    stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && slots[i].vld && (slots[i].rd == src) && (src != '0)) begin
        found = 1'b1;
        if (slots[i].rem == '0) begin
          sel = SELW'(i + 1);
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: tracks in-flight producers, selects bypass sources and stalls issue.
module forward_scoreboard
  import forward_scoreboard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int NSRC   = 2,
  parameter int REGW   = REGW_DEF,
  parameter int LATW   = LATW_DEF,
  parameter int FLUSHN = 1,
  localparam int SELW  = fwd_sel_width(DEPTH)
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      adv,
  input  logic                      flush,
  input  logic                      iss_vld,
  input  logic                      iss_regwr,
  input  logic [REGW-1:0]           iss_rd,
  input  logic [LATW-1:0]           iss_lat,
  input  logic [NSRC-1:0][REGW-1:0] src_rs,
  output logic [NSRC-1:0][SELW-1:0] fwd_sel,
  output logic                      stall,
  output logic [15:0]               hazard_cnt
);

  slot_t [DEPTH-1:0]         slots;
  slot_t [DEPTH-1:0]         slots_next;
  logic  [NSRC-1:0][SELW-1:0] match_sel;
  logic  [NSRC-1:0]          match_stall;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    fwd_match #(
      .DEPTH (DEPTH),
      .SELW  (SELW)
    ) u_match (
      .slots (slots),
      .src   (regbits_t'(src_rs[s])),
      .sel   (match_sel[s]),
      .stall (match_stall[s])
    );
  end

  // Outputs are forced quiet while reset is asserted, since slot state may be stale.
  always_comb begin
    stall   = nRST && iss_vld && (|match_stall);
    fwd_sel = nRST ? match_sel : '0;
  end

  always_comb begin
    slots_next = slots;
    if (adv) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        slots_next[i] = slots[i-1];
        if (slots[i-1].rem != '0) begin
          slots_next[i].rem = slots[i-1].rem - latbits_t'(1);
        end
      end
      if (stall) begin
        slots_next[0] = '0;
      end else begin
        slots_next[0].vld = iss_vld && iss_regwr && (iss_rd != '0);
        slots_next[0].rd  = regbits_t'(iss_rd);
        slots_next[0].rem = latbits_t'(iss_lat);
      end
    end
    // Flush acts on the post-shift view, so a same-cycle issue is squashed too.
    if (flush) begin
      for (int i = 0; i < FLUSHN && i < DEPTH; i++) begin
        slots_next[i].vld = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      slots      <= '0;
      hazard_cnt <= '0;
    end else begin
      slots <= slots_next;
      if (adv && stall && (hazard_cnt != 16'hFFFF)) begin
        hazard_cnt <= hazard_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Self-checking bench for forward_scoreboard: queue-based reference model plus directed literal scenarios.
module tb_forward_scoreboard;

  localparam int DEPTH  = 3;
  localparam int NSRC   = 2;
  localparam int REGW   = 5;
  localparam int LATW   = 2;
  localparam int FLUSHN = 1;
  localparam int SELW   = 2;

  logic                      CLK;
  logic                      nRST;
  logic                      adv;
  logic                      flush;
  logic                      iss_vld;
  logic                      iss_regwr;
  logic [REGW-1:0]           iss_rd;
  logic [LATW-1:0]           iss_lat;
  logic [NSRC-1:0][REGW-1:0] src_rs;
  logic [NSRC-1:0][SELW-1:0] fwd_sel;
  logic                      stall;
  logic [15:0]               hazard_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  forward_scoreboard #(
    .DEPTH  (DEPTH),
    .NSRC   (NSRC),
    .REGW   (REGW),
    .LATW   (LATW),
    .FLUSHN (FLUSHN)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .adv        (adv),
    .flush      (flush),
    .iss_vld    (iss_vld),
    .iss_regwr  (iss_regwr),
    .iss_rd     (iss_rd),
    .iss_lat    (iss_lat),
    .src_rs     (src_rs),
    .fwd_sel    (fwd_sel),
    .stall      (stall),
    .hazard_cnt (hazard_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: a list of producers, youngest at the front, each counting down to ready.
  typedef struct {
    bit vld;
    int rd;
    int rem;
  } entry_t;

  entry_t pipe[$];
  int     model_cnt   = 0;
  bit     model_ready = 1'b0;

  function automatic int model_sel(input int src, output bit st);
    st = 1'b0;
    if (src == 0) return 0;
    for (int i = 0; i < pipe.size(); i++) begin
      if (pipe[i].vld && pipe[i].rd == src) begin
        if (pipe[i].rem == 0) return i + 1;
        st = 1'b1;
        return 0;
      end
    end
    return 0;
  endfunction

  function automatic bit model_stall();
    bit st;
    if (!nRST || !iss_vld) return 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      void'(model_sel(int'(src_rs[s]), st));
      if (st) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Advance the model at each edge using the inputs the DUT sees there.
  always @(posedge CLK) begin
    entry_t e;
    bit     st;
    if (!nRST) begin
      pipe.delete();
      for (int i = 0; i < DEPTH; i++) pipe.push_back('{vld: 1'b0, rd: 0, rem: 0});
      model_cnt   = 0;
      model_ready = 1'b1;
    end else if (model_ready) begin
      st = model_stall();
      if (adv) begin
        void'(pipe.pop_back());
        foreach (pipe[i]) if (pipe[i].rem > 0) pipe[i].rem--;
        e.vld = !st && iss_vld && iss_regwr && (iss_rd != 0);
        e.rd  = st ? 0 : int'(iss_rd);
        e.rem = st ? 0 : int'(iss_lat);
        pipe.push_front(e);
        if (st && model_cnt < 65535) model_cnt++;
      end
      if (flush) for (int i = 0; i < FLUSHN; i++) pipe[i].vld = 1'b0;
    end
  end

  always @(negedge CLK) begin
    bit st;
    int e;
    if (model_ready) begin
      for (int s = 0; s < NSRC; s++) begin
        e = nRST ? model_sel(int'(src_rs[s]), st) : 0;
        check_output($sformatf("model fwd_sel[%0d]", s), int'(fwd_sel[s]), e);
      end
      check_output("model stall", int'(stall), int'(model_stall()));
      check_output("model hazard_cnt", int'(hazard_cnt), model_cnt);
    end
  end

  task automatic apply_stimulus(input bit a, input bit f, input bit v, input bit w,
                                input int rd, input int lat, input int s0, input int s1);
    @(posedge CLK);
    #1;
    adv       = a;
    flush     = f;
    iss_vld   = v;
    iss_regwr = w;
    iss_rd    = REGW'(rd);
    iss_lat   = LATW'(lat);
    src_rs[0] = REGW'(s0);
    src_rs[1] = REGW'(s1);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    nRST    = 1'b0;
    adv     = 1'b1;
    flush   = 1'b0;
    iss_vld = 1'b0;
    src_rs  = '0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    nRST      = 1'b0;
    adv       = 1'b1;
    flush     = 1'b0;
    iss_vld   = 1'b0;
    iss_regwr = 1'b0;
    iss_rd    = '0;
    iss_lat   = '0;
    src_rs    = '0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(negedge CLK);
    check_output("reset hazard_cnt", int'(hazard_cnt), 0);
    check_output("reset stall", int'(stall), 0);

    // ALU result forwards from slot 0, then slot 1.
    do_reset();
    apply_stimulus(1, 0, 1, 1, 3, 0, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0, 0, 3, 0);
    check_output("alu stall", int'(stall), 0);
    check_output("alu fwd_sel first", int'(fwd_sel[0]), 1);
    apply_stimulus(1, 0, 1, 0, 0, 0, 3, 0);
    check_output("alu fwd_sel second", int'(fwd_sel[0]), 2);

    // Load-use: one bubble, then forward from slot 1.
    do_reset();
    apply_stimulus(1, 0, 1, 1, 5, 1, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0, 0, 5, 0);
    check_output("load stall", int'(stall), 1);
    check_output("load fwd_sel during stall", int'(fwd_sel[0]), 0);
    apply_stimulus(1, 0, 1, 0, 0, 0, 5, 0);
    check_output("load stall released", int'(stall), 0);
    check_output("load fwd_sel after bubble", int'(fwd_sel[0]), 2);
    check_output("load hazard_cnt", int'(hazard_cnt), 1);

    // Youngest producer wins.
    do_reset();
    apply_stimulus(1, 0, 1, 1, 7, 0, 0, 0);
    apply_stimulus(1, 0, 1, 1, 7, 0, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0, 0, 0, 7);
    check_output("youngest fwd_sel", int'(fwd_sel[1]), 1);

    // r0 never matches; unknown register reads the register file.
    do_reset();
    apply_stimulus(1, 0, 1, 1, 0, 0, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0, 0, 0, 9);
    check_output("r0 fwd_sel", int'(fwd_sel[0]), 0);
    check_output("no producer fwd_sel", int'(fwd_sel[1]), 0);
    check_output("r0 stall", int'(stall), 0);

    // Freeze holds a pending hazard; flush clears it.
    do_reset();
    apply_stimulus(1, 0, 1, 1, 4, 2, 0, 0);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 0, 1, 0, 0, 0, 4, 0);
      check_output($sformatf("freeze stall %0d", k), int'(stall), 1);
      check_output($sformatf("freeze hazard_cnt %0d", k), int'(hazard_cnt), 0);
    end
    apply_stimulus(0, 1, 1, 0, 0, 0, 4, 0);
    apply_stimulus(0, 0, 1, 0, 0, 0, 4, 0);
    check_output("flush stall", int'(stall), 0);
    check_output("flush fwd_sel", int'(fwd_sel[0]), 0);

    // Flush squashes a same-cycle issue.
    do_reset();
    apply_stimulus(1, 1, 1, 1, 6, 0, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0, 0, 6, 0);
    check_output("flush-issue fwd_sel", int'(fwd_sel[0]), 0);

    // Randomized traffic, including occasional mid-run resets.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      @(posedge CLK);
      #1;
      nRST      = ($urandom_range(0, 63) != 0);
      adv       = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      iss_vld   = ($urandom_range(0, 3) != 0);
      iss_regwr = ($urandom_range(0, 3) != 0);
      iss_rd    = REGW'($urandom_range(0, 7));
      iss_lat   = LATW'($urandom_range(0, 3));
      src_rs[0] = REGW'($urandom_range(0, 7));
      src_rs[1] = REGW'($urandom_range(0, 7));
    end

    // Saturate the hazard counter: one lat-3 producer then three stalled issues, repeated.
    do_reset();
    for (int g = 0; g < 21846; g++) begin
      apply_stimulus(1, 0, 1, 1, 1, 3, 2, 2);
      repeat (3) apply_stimulus(1, 0, 1, 0, 0, 0, 1, 0);
    end
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
    check_output("saturated hazard_cnt", int'(hazard_cnt), 16'hFFFF);
    apply_stimulus(1, 0, 1, 1, 1, 3, 2, 2);
    apply_stimulus(1, 0, 1, 0, 0, 0, 1, 0);
    check_output("pre-reset stall", int'(stall), 1);
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    @(negedge CLK);
    check_output("in-reset stall", int'(stall), 0);
    check_output("in-reset fwd_sel", int'(fwd_sel[0]), 0);
    check_output("sticky hazard_cnt", int'(hazard_cnt), 16'hFFFF);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(negedge CLK);
    check_output("post-reset hazard_cnt", int'(hazard_cnt), 0);
    check_output("post-reset stall", int'(stall), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3, meaning the number of in-flight producer slots tracked beyond issue (slot 0 = youngest).
REQ-002 Parameter NSRC, default 2, meaning the number of source operands checked per issued instruction.
REQ-003 Parameter REGW, default 5, meaning the register index width.
REQ-004 Parameter LATW, default 2, meaning the width of the result-latency field.
REQ-005 Parameter FLUSHN, default 1, meaning the number of youngest slots cleared by flush.
REQ-006 CLK  in  1  the single clock; all state changes on its rising edge.
REQ-007 nRST  in  1  reset, synchronous, active-low.
REQ-008 adv  in  1  pipeline advance enable; 0 = global freeze.
REQ-009 flush  in  1  squash the youngest FLUSHN slots.
REQ-010 iss_vld  in  1  an instruction is presented for issue.
REQ-011 iss_regwr  in  1  the issued instruction writes a register.
REQ-012 iss_rd  in  REGW  destination register of the issued instruction.
REQ-013 iss_lat  in  LATW  advances after issue before its result is forwardable (0 = ALU, 1 = load).
REQ-014 src_rs  in  NSRC x REGW  source registers of the issued instruction.
REQ-015 fwd_sel  out  NSRC x clog2(DEPTH+1)  per source: 0 = register file, k = forward from slot k-1.
REQ-016 stall  out  1  issue must hold; the block inserts a bubble.
REQ-017 hazard_cnt  out  16  count of stalled advance cycles, saturating.

Function
REQ-018 Each slot SHALL hold vld, rd (REGW) and rem (LATW) as registered state.
REQ-019 Source s SHALL match slot i when slot i is valid, rd equals src_rs[s], and src_rs[s] is nonzero; register 0 never matches.
REQ-020 The youngest matching slot (lowest i) SHALL take priority; older matches are ignored.
REQ-021 If the youngest match has rem = 0, fwd_sel[s] SHALL be i+1; if there is no match, it SHALL be 0.
REQ-022 If the youngest match has rem > 0, stall SHALL be 1 and fwd_sel[s] SHALL be 0.
REQ-023 stall and fwd_sel SHALL be combinational from slot state and src_rs, with no cycle of latency; stall SHALL be 0 when iss_vld = 0.
REQ-024 When adv=1 and stall=0, slots SHALL shift (slot i+1 takes slot i, and the oldest is discarded).
REQ-025 In the REQ-024 case, slot 0 SHALL load {iss_vld && iss_regwr && iss_rd != 0, iss_rd, iss_lat}.
REQ-026 When adv=1 and stall=1, slots SHALL shift and slot 0 SHALL load a bubble (vld = 0).
REQ-027 On every shift, rem SHALL decrement, saturating at 0, as the entry moves.
REQ-028 When adv=0, all slots and hazard_cnt SHALL hold; outputs still reflect current state.
REQ-029 flush SHALL be applied after the shift and SHALL clear vld in slots 0..FLUSHN-1; this applies even when adv=0.
REQ-030 flush and issue in the same cycle SHALL result in a cleared slot 0 (flush wins).
REQ-031 hazard_cnt SHALL increment when adv=1 and stall=1, and SHALL stick at 0xFFFF.

Reset
REQ-032 When nRST=0 at a clock edge, all slots SHALL become invalid and hazard_cnt SHALL become 0.
REQ-033 While in reset, stall SHALL be 0 and fwd_sel SHALL be all 0.
REQ-034 Reset SHALL take priority over adv and flush; a reset mid-stall SHALL drop the pending hazard.

Structure
REQ-035 A shared package SHALL define the slot entry struct (vld, rd, rem), the regbits_t width, and the fwd-select width function.
REQ-036 A per-source sub-module fwd_match (youngest-match priority encode, returning sel and stall) SHALL be instantiated NSRC times.
REQ-037 A per-source sub-module is the only one natural here.

Verification
REQ-038 Issue ALU add r3 (lat 0), then next cycle src r3 -> stall=0, fwd_sel=1; one advance later src r3 -> fwd_sel=2.
REQ-039 Issue load r5 (lat 1), then next cycle src r5 -> stall=1 and a bubble inserted; on the following cycle fwd_sel=2 and stall=0, with hazard_cnt=1.
REQ-040 Issue r7 twice on consecutive cycles, then src r7 -> fwd_sel=1 (youngest wins, not 2).
REQ-041 Issue a write to r0 with src r0 -> no slot valid and fwd_sel=0; src r9 with no producer -> fwd_sel=0.
REQ-042 With load r4 in slot 0, hold adv=0 for 3 cycles -> stall held at 1, slots unchanged, hazard_cnt unchanged; then flush=1 -> slot 0 cleared and stall=0.
REQ-043 Drive stall for 70000 advance cycles -> hazard_cnt=0xFFFF; then nRST=0 for one edge -> slots invalid and hazard_cnt=0.
